// File: rtl/sid_pkg.sv
// Shared constants and bus types for the SID voice front end, envelope and oscillator blocks.
package sid_pkg;

  localparam int VOICE_STRIDE = 7;
  localparam int OFS_CTRL     = 4;
  localparam int OFS_AD       = 5;
  localparam int OFS_SR       = 6;

  localparam logic [4:0] REG_OSC3 = 5'h1B;
  localparam logic [4:0] REG_ENV3 = 5'h1C;

  typedef enum logic {
    BUS_READ  = 1'b0,
    BUS_WRITE = 1'b1
  } bus_op_t;

  typedef struct packed {
    bus_op_t    op;
    logic [4:0] addr;
    logic [7:0] wdata;
  } bus_cmd_t;

  // Register address of a per-voice register, given the voice index and register offset.
  function automatic logic [4:0] voice_reg(input int v, input int ofs);
    return 5'(v * VOICE_STRIDE + ofs);
  endfunction

endpackage

// File: rtl/sid_tick_gen.sv
// Envelope clock enable generator: a free-running 0..CLK_DIV-1 counter with a
// registered one-clock tick in the cycle where the counter holds CLK_DIV-1.
module sid_tick_gen #(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // The tick is registered from the next count so it lines up with the cycle holding LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      tick <= (cnt_next == LAST);
    end
  end

endmodule

// File: rtl/sid_voice_ctrl.sv
// Host register front end and gate sequencer for the SID envelope generators.
// Optional feature macro: SID_GATE_RELEASE_HOLD_EN (forces every gate release to last at least one tick).
module sid_voice_ctrl
  import sid_pkg::*;
#(
  parameter int CLK_DIV    = 32,
  parameter int NUM_VOICES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bus_req,
  input  logic                    bus_we,
  input  logic [4:0]              bus_addr,
  input  logic [7:0]              bus_wdata,
  output logic                    bus_ack,
  output logic [7:0]              bus_rdata,
  input  logic [7:0]              osc3_in,
  input  logic [7:0]              env3_vol,
  output logic                    env_clk_en,
  output logic [4*NUM_VOICES-1:0] atk,
  output logic [4*NUM_VOICES-1:0] dcy,
  output logic [4*NUM_VOICES-1:0] stn,
  output logic [4*NUM_VOICES-1:0] rls,
  output logic [NUM_VOICES-1:0]   gate
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [0:0]            state;
  bus_cmd_t              cmd;
  logic                  accept;
  logic [7:0]            read_mux;
  logic [NUM_VOICES-1:0] ctrl_wr;
  logic [NUM_VOICES-1:0] ad_wr;
  logic [NUM_VOICES-1:0] sr_wr;
  logic [NUM_VOICES-1:0] shadow;

  assign cmd    = '{op: bus_op_t'(bus_we), addr: bus_addr, wdata: bus_wdata};
  assign accept = bus_req && (state == S_IDLE);

  sid_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (env_clk_en)
  );

  always_comb begin
    ctrl_wr = '0;
    ad_wr   = '0;
    sr_wr   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (accept && (cmd.op == BUS_WRITE)) begin
        ctrl_wr[v] = (cmd.addr == voice_reg(v, OFS_CTRL));
        ad_wr[v]   = (cmd.addr == voice_reg(v, OFS_AD));
        sr_wr[v]   = (cmd.addr == voice_reg(v, OFS_SR));
      end
    end
  end

  always_comb begin
    read_mux = 8'h00;
    case (cmd.addr)
      REG_OSC3: read_mux = osc3_in;
      REG_ENV3: read_mux = env3_vol;
      default:  read_mux = 8'h00;
    endcase
  end

  // Readback is captured at accept so the host sees the value present when it asked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      bus_ack   <= 1'b0;
      bus_rdata <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_ACK;
            bus_ack   <= 1'b1;
            bus_rdata <= (cmd.op == BUS_READ) ? read_mux : 8'h00;
          end
        end
        default: begin
          state     <= S_IDLE;
          bus_ack   <= 1'b0;
          bus_rdata <= 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      atk    <= '0;
      dcy    <= '0;
      stn    <= '0;
      rls    <= '0;
      shadow <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (ad_wr[v]) begin
          atk[4*v +: 4] <= cmd.wdata[7:4];
          dcy[4*v +: 4] <= cmd.wdata[3:0];
        end
        if (sr_wr[v]) begin
          stn[4*v +: 4] <= cmd.wdata[7:4];
          rls[4*v +: 4] <= cmd.wdata[3:0];
        end
        if (ctrl_wr[v]) begin
          shadow[v] <= cmd.wdata[0];
        end
      end
    end
  end

`ifdef SID_GATE_RELEASE_HOLD_EN
  logic [NUM_VOICES-1:0] rel_pend;

  // A falling shadow gate is remembered until the next tick so a short 0 pulse is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      rel_pend <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (ctrl_wr[v] && shadow[v] && !cmd.wdata[0]) begin
          rel_pend[v] <= 1'b1;
        end else if (env_clk_en) begin
          rel_pend[v] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate <= '0;
    end else if (env_clk_en) begin
      gate <= shadow & ~rel_pend;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      gate <= '0;
    end else if (env_clk_en) begin
      gate <= shadow;
    end
  end
`endif

endmodule

// File: tb/tb_sid_voice_ctrl.sv
// Scoreboard bench for sid_voice_ctrl: bus expectations are queued at issue and checked on bus_ack.
module tb_sid_voice_ctrl;

  localparam int CLK_DIV = 32;
  localparam int NV      = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = 5'h00;
  logic [7:0]  bus_wdata = 8'h00;
  logic [7:0]  osc3_in = 8'h00;
  logic [7:0]  env3_vol = 8'h00;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        env_clk_en;
  logic [11:0] atk, dcy, stn, rls;
  logic [2:0]  gate;

  sid_voice_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .NUM_VOICES(NV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .osc3_in   (osc3_in),
    .env3_vol  (env3_vol),
    .env_clk_en(env_clk_en),
    .atk       (atk),
    .dcy       (dcy),
    .stn       (stn),
    .rls       (rls),
    .gate      (gate)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rdata;
    logic [11:0] atk;
    logic [11:0] dcy;
    logic [11:0] stn;
    logic [11:0] rls;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon;
  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] expAtk = '0, expDcy = '0, expStn = '0, expRls = '0;
  int          refCnt = 0;
  bit          monEn = 1'b0;

  // Reference tick position: the counter value held during the current cycle.
  always @(posedge clk) begin
    if (reset) refCnt <= 0;
    else       refCnt <= (refCnt == CLK_DIV - 1) ? 0 : refCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("tick", 64'(env_clk_en), 64'(refCnt == CLK_DIV - 1));
      if (bus_ack) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpectedAck", 64'(bus_ack), 64'd0);
        end else begin
          mon = sbq.pop_front();
          checkOutput("ackRdata", 64'(bus_rdata), 64'(mon.rdata));
          checkOutput("ackRegs", {atk, dcy, stn, rls}, {mon.atk, mon.dcy, mon.stn, mon.rls});
        end
      end else begin
        checkOutput("idleRdata", 64'(bus_rdata), 64'd0);
      end
    end
  end

  task automatic applyStimulus(input bit we, input logic [4:0] addr, input logic [7:0] wdata,
                               input logic [7:0] expRdata);
    exp_t e;
    int   lat;
    bit   seen;
    e.rdata = expRdata;
    e.atk   = expAtk;
    e.dcy   = expDcy;
    e.stn   = expStn;
    e.rls   = expRls;
    sbq.push_back(e);
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_req   = 1'b1;
    lat  = 0;
    seen = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_ack) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    checkOutput("ackLatency", 64'(lat), 64'd1);
    @(posedge clk);
    #1;
    bus_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  p[$];
    bit  sawTick;
    int  ticks;
    logic g0;

    @(posedge clk);
    #1;
    monEn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Test 1: tick placement and reset state
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (env_clk_en) p.push_back(cyc);
      if (cyc == 0) begin
        checkOutput("resetAdsr", {atk, dcy, stn, rls}, 64'd0);
        checkOutput("resetGate", 64'(gate), 64'd0);
        checkOutput("resetAck", 64'(bus_ack), 64'd0);
      end
    end
    checkOutput("pulseCount", 64'(p.size()), 64'd2);
    checkOutput("pulse0", 64'(p.size() > 0 ? p[0] : 999), 64'd31);
    checkOutput("pulse1", 64'(p.size() > 1 ? p[1] : 999), 64'd63);
    @(posedge clk);
    #1;

    // Test 2: ADSR writes per voice, plus discarded addresses
    expAtk = 12'h009; expDcy = 12'h00A;
    applyStimulus(1'b1, 5'h05, 8'h9A, 8'h00);
    expStn = 12'h004; expRls = 12'h00F;
    applyStimulus(1'b1, 5'h06, 8'h4F, 8'h00);
    expAtk = 12'h039; expDcy = 12'h07A;
    applyStimulus(1'b1, 5'h0C, 8'h37, 8'h00);
    expStn = 12'hE04; expRls = 12'h10F;
    applyStimulus(1'b1, 5'h14, 8'hE1, 8'h00);
    applyStimulus(1'b1, 5'h1F, 8'hFF, 8'h00);
    applyStimulus(1'b1, 5'h03, 8'hFF, 8'h00);

    // Test 3: gate write at counter 5 appears after the next tick
    for (int i = 0; i < 64 && refCnt != 5; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("syncCnt5", 64'(refCnt), 64'd5);
    applyStimulus(1'b1, 5'h0B, 8'h01, 8'h00);
    sawTick = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("gate1Align", 64'(gate), sawTick ? 64'h2 : 64'h0);
      if (refCnt == CLK_DIV - 1) sawTick = 1'b1;
    end
    @(posedge clk);
    #1;

    // Test 4: short release pulse on voice 0
    applyStimulus(1'b1, 5'h04, 8'h01, 8'h00);
    @(posedge clk);
    #1;
    for (int i = 0; i < 64 && refCnt != 1; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("gate0Set", 64'(gate), 64'h3);
    applyStimulus(1'b1, 5'h04, 8'h00, 8'h00);
    applyStimulus(1'b1, 5'h04, 8'h01, 8'h00);
    ticks = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
`ifdef SID_GATE_RELEASE_HOLD_EN
      g0 = (ticks == 1) ? 1'b0 : 1'b1;
`else
      g0 = 1'b1;
`endif
      checkOutput("gate0Hold", 64'(gate), 64'({2'b01, g0}));
      if (refCnt == CLK_DIV - 1) ticks++;
    end
    @(posedge clk);
    #1;

    // Test 5: readback
    env3_vol = 8'h5D;
    osc3_in  = 8'hC3;
    applyStimulus(1'b0, 5'h1C, 8'h00, 8'h5D);
    applyStimulus(1'b0, 5'h1B, 8'h00, 8'hC3);
    applyStimulus(1'b0, 5'h05, 8'h00, 8'h00);

    // Test 6: reset in the accept cycle cancels the request, which is then re-accepted
    bus_we    = 1'b1;
    bus_addr  = 5'h05;
    bus_wdata = 8'h77;
    bus_req   = 1'b1;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    expAtk = 12'h007; expDcy = 12'h007; expStn = 12'h000; expRls = 12'h000;
    begin
      exp_t e;
      e.rdata = 8'h00;
      e.atk   = expAtk;
      e.dcy   = expDcy;
      e.stn   = expStn;
      e.rls   = expRls;
      sbq.push_back(e);
    end
    @(negedge clk);
    checkOutput("noAckOnReset", 64'(bus_ack), 64'd0);
    checkOutput("regsAfterReset", {atk, dcy, stn, rls}, 64'd0);
    checkOutput("gateAfterReset", 64'(gate), 64'd0);
    @(negedge clk);
    checkOutput("reAccept", 64'(bus_ack), 64'd1);
    @(posedge clk);
    #1;
    bus_req = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    checkOutput("queueEmpty", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
